profir_sequencer: RTL and testbench

- Control sequencer for the 8-filter, 128-tap polyphase FIR bank.
- Each accepted din_enable strobe starts one full computation pass:
  - writes the new sample into a 128-entry circular sample buffer;
  - walks the 64-word coefficient memories, two 18-bit taps per 36-bit word;
  - generates the matching pair of sample-buffer read addresses;
  - drives the MAC clear/enable/last controls and an output-valid strobe.
- Replaces the free-running coefficient address counter with a bounded, overrun-checked schedule.

---
 rtl/profir_sequencer.sv | 168 ++++++++++++++++
 tb/tb_profir_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/profir_sequencer.sv
// profir_sequencer: control sequencer for the 8-filter, 128-tap polyphase FIR bank.
// Each accepted din_enable runs one pass. The pass writes the new sample into the
// circular sample buffer, then walks the coefficient memories at two taps per word
// while it generates the paired sample read addresses. It also drives the MAC
// clear/enable/last controls and ends with a one-cycle dout_valid.
//
// Ports:
//   clock, reset (async, active low)
//   din_enable     new-sample strobe
//   overrun_clear  clears sticky overrun (and drop_count when enabled)
//   wr_enable, wr_address            sample buffer write
//   coeffaddress                     coefficient memory read address (tap pair k)
//   sampaddr0, sampaddr1             sample reads for even / odd tap of pair k
//   mac_enable, mac_clear, mac_last  MAC controls, aligned to read data
//   dout_valid                       result ready strobe
//   busy, overrun                    pass in progress / din_enable seen while busy
//   drop_count                       only with PROFIR_SEQ_DROPCOUNT_EN: saturating
//                                    count of ignored strobes
//
// Optional feature macro: PROFIR_SEQ_DROPCOUNT_EN
//
// state | meaning
// IDLE  | waiting for din_enable
// WRITE | write new sample at wr_ptr, latch pass base
// RUN   | one coefficient word per cycle, k = 0..NTAPS/2-1
// DRAIN | RD_LAT cycles for the last read data to reach the MACs
// DONE  | dout_valid; a din_enable here starts the next pass directly
module profir_sequencer #(
  parameter int NTAPS   = 128,
  parameter int CADDR_W = 6,
  parameter int SADDR_W = 7,
  parameter int RD_LAT  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din_enable,
  input  logic               overrun_clear,
  output logic               wr_enable,
  output logic [SADDR_W-1:0] wr_address,
  output logic [CADDR_W-1:0] coeffaddress,
  output logic [SADDR_W-1:0] sampaddr0,
  output logic [SADDR_W-1:0] sampaddr1,
  output logic               mac_enable,
  output logic               mac_clear,
  output logic               mac_last,
  output logic               dout_valid,
  output logic               busy,
  output logic               overrun
`ifdef PROFIR_SEQ_DROPCOUNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  typedef enum logic [2:0] {IDLE, WRITE, RUN, DRAIN, DONE} state_t;

  localparam logic [CADDR_W-1:0] K_LAST = CADDR_W'(NTAPS/2 - 1);

  state_t             state, state_nxt;
  logic [SADDR_W-1:0] wr_ptr;
  logic [CADDR_W-1:0] k;
  logic [1:0]         drain_cnt;
  logic               in_pass;
  logic               nxt_in_pass;
  logic               accept;
  logic               ignored;
  logic [RD_LAT-1:0]  en_pipe, clr_pipe, last_pipe;

  assign in_pass     = (state == WRITE) || (state == RUN) || (state == DRAIN);
  assign nxt_in_pass = (state_nxt == WRITE) || (state_nxt == RUN) || (state_nxt == DRAIN);
  assign accept      = din_enable && ((state == IDLE) || (state == DONE));
  assign ignored     = din_enable && in_pass;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_enable) state_nxt = WRITE;
      WRITE:   state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = din_enable ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample addresses step down by two per coefficient word: newest sample pairs
  // with tap 0, and the odd tap of each pair reads one sample further back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      wr_enable  <= 1'b0;
      wr_address <= '0;
      k          <= '0;
      sampaddr0  <= '0;
      sampaddr1  <= '0;
      drain_cnt  <= 2'd0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_enable  <= accept;
      busy       <= nxt_in_pass;
      dout_valid <= (state_nxt == DONE);
      if (accept) wr_address <= wr_ptr;
      case (state)
        WRITE: begin
          wr_ptr    <= wr_ptr + SADDR_W'(1);
          k         <= '0;
          sampaddr0 <= wr_ptr;
          sampaddr1 <= wr_ptr - SADDR_W'(1);
        end
        RUN: begin
          if (k != K_LAST) begin
            k         <= k + CADDR_W'(1);
            sampaddr0 <= sampaddr0 - SADDR_W'(2);
            sampaddr1 <= sampaddr1 - SADDR_W'(2);
          end else begin
            drain_cnt <= 2'(RD_LAT - 1);
          end
        end
        DRAIN:   if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
        DONE:    k <= '0;
        default: ;
      endcase
      if (ignored)            overrun <= 1'b1;
      else if (overrun_clear) overrun <= 1'b0;
    end
  end

  assign coeffaddress = k;

  // MAC strobes track the read data, not the FSM, so they trail RUN by RD_LAT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_pipe   <= '0;
      clr_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      en_pipe[0]   <= (state == RUN);
      clr_pipe[0]  <= (state == RUN) && (k == '0);
      last_pipe[0] <= (state == RUN) && (k == K_LAST);
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        clr_pipe[i]  <= clr_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign mac_enable = en_pipe[RD_LAT-1];
  assign mac_clear  = clr_pipe[RD_LAT-1];
  assign mac_last   = last_pipe[RD_LAT-1];

`ifdef PROFIR_SEQ_DROPCOUNT_EN
  // Clear takes priority so a clear always leaves the count at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           drop_count <= 8'd0;
    else if (overrun_clear)               drop_count <= 8'd0;
    else if (ignored && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_profir_sequencer.sv
// tb_profir_sequencer: scoreboard bench for profir_sequencer.
// The stimulus queues the expected write, address, MAC and dout events for every
// accepted strobe. A negedge monitor pops and compares these events as the DUT
// presents them.
module tb_profir_sequencer;
  localparam int L  = 1;
  localparam int NT = 128;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       din_enable = 1'b0;
  logic       overrun_clear = 1'b0;
  logic       wr_enable;
  logic [6:0] wr_address;
  logic [5:0] coeffaddress;
  logic [6:0] sampaddr0, sampaddr1;
  logic       mac_enable, mac_clear, mac_last, dout_valid, busy, overrun;
`ifdef PROFIR_SEQ_DROPCOUNT_EN
  logic [7:0] drop_count;
`endif

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {int cyc; int v0; int v1; int v2;} ev_t;
  ev_t wr_q[$], dout_q[$], mac_q[$], addr_q[$];

  profir_sequencer #(.NTAPS(NT), .CADDR_W(6), .SADDR_W(7), .RD_LAT(L)) dut (
    .clock(clock), .reset(reset), .din_enable(din_enable), .overrun_clear(overrun_clear),
    .wr_enable(wr_enable), .wr_address(wr_address), .coeffaddress(coeffaddress),
    .sampaddr0(sampaddr0), .sampaddr1(sampaddr1), .mac_enable(mac_enable),
    .mac_clear(mac_clear), .mac_last(mac_last), .dout_valid(dout_valid),
    .busy(busy), .overrun(overrun)
`ifdef PROFIR_SEQ_DROPCOUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input bit accept, input int addr);
    int t;
    t = cyc;
    if (accept) begin
      wr_q.push_back('{t + 1, addr, 0, 0});
      for (int k = 0; k < NT/2; k++) begin
        addr_q.push_back('{t + 2 + k, k, (addr - 2*k) & (NT-1), (addr - 2*k - 1) & (NT-1)});
        mac_q.push_back('{t + 2 + L + k, int'(k == 0), int'(k == NT/2-1), 0});
      end
      dout_q.push_back('{t + 66 + L, 0, 0, 0});
    end
    din_enable = 1'b1;
    @(posedge clock);
    #1;
    din_enable = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_enable, 0);
    check({tag, "_wr_addr"}, wr_address, 0);
    check({tag, "_coeff"}, coeffaddress, 0);
    check({tag, "_sa0"}, sampaddr0, 0);
    check({tag, "_sa1"}, sampaddr1, 0);
    check({tag, "_mac"}, {mac_enable, mac_clear, mac_last}, 0);
    check({tag, "_dout"}, dout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (reset) begin
      if (wr_enable) begin
        if (wr_q.size() == 0) flag("wr_extra");
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", wr_address, e.v0);
        end
      end
      if (dout_valid) begin
        if (dout_q.size() == 0) flag("dout_extra");
        else begin
          e = dout_q.pop_front();
          check("dout_cycle", cyc, e.cyc);
        end
      end
      if (mac_enable) begin
        if (mac_q.size() == 0) flag("mac_extra");
        else begin
          e = mac_q.pop_front();
          check("mac_cycle", cyc, e.cyc);
          check("mac_clear", mac_clear, e.v0);
          check("mac_last", mac_last, e.v1);
        end
      end else if (mac_clear || mac_last) flag("mac_strobe_no_enable");
      if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
        e = addr_q.pop_front();
        check("coeffaddr", coeffaddress, e.v0);
        check("sampaddr0", sampaddr0, e.v1);
        check("sampaddr1", sampaddr1, e.v2);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: cycle %0d reached limit", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int a;
    goto(1);
    check_zero("reset");
    goto(3);
    reset = 1'b1;

    goto(10);
    check("busy_idle", busy, 0);
    check("coeff_idle", coeffaddress, 0);
    issue(1'b1, 0);
    check("busy_write", busy, 1);

    goto(40);
    check("ovr_before", overrun, 0);
    issue(1'b0, 0);
    check("ovr_set", overrun, 1);

    goto(76);
    check("busy_drain", busy, 1);
    check("drain_coeff", coeffaddress, 63);
    check("drain_sa0", sampaddr0, 2);
    check("drain_sa1", sampaddr1, 1);

    goto(77);
    check("busy_done", busy, 0);
    check("ovr_sticky", overrun, 1);
    issue(1'b1, 1);

    goto(90);
    check("ovr_hold", overrun, 1);
    overrun_clear = 1'b1;
    @(posedge clock);
    #1;
    overrun_clear = 1'b0;
    check("ovr_cleared", overrun, 0);

    goto(144);
    issue(1'b1, 2);
    goto(146);
    check("b2b_no_ovr", overrun, 0);

    goto(220);
    issue(1'b1, 3);
    goto(240);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    addr_q.delete();
    mac_q.delete();
    dout_q.delete();
    goto(245);
    reset = 1'b1;

    t = 250;
    goto(t);
    issue(1'b1, 0);
    for (int i = 1; i < NT; i++) begin
      t += 66 + L;
      goto(t);
      issue(1'b1, i);
    end
    t += 66 + L;
    goto(t);
    issue(1'b1, 0);
    a = 1;

`ifdef PROFIR_SEQ_DROPCOUNT_EN
    for (int p = 0; p < 5; p++) begin
      t += 66 + L;
      goto(t);
      issue(1'b1, a);
      a = (a + 1) & (NT-1);
      for (int j = 0; j < 65 + L; j++) issue(1'b0, 0);
    end
    goto(t + 66 + L + 2);
    check("drop_sat", drop_count, 255);
    check("drop_ovr", overrun, 1);
    overrun_clear = 1'b1;
    @(posedge clock);
    #1;
    overrun_clear = 1'b0;
    check("drop_clear", drop_count, 0);
    check("drop_ovr_clear", overrun, 0);
`endif

    goto(t + 66 + L + 4);
    check("busy_end", busy, 0);
    check("wr_q_left", wr_q.size(), 0);
    check("addr_q_left", addr_q.size(), 0);
    check("mac_q_left", mac_q.size(), 0);
    check("dout_q_left", dout_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
